// File: rtl/dmem_pkg.sv
// dmem_pkg
//   Shared definitions for the data-memory responder: FSM state encoding,
//   request field widths, the wait-state limit and the access-error rule.
//   Imported by dmem_responder and dmem_sram_array.
package dmem_pkg;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int BE_W        = DATA_W / 8;
    localparam int MAX_LATENCY = 15;
    localparam int CNT_W       = $clog2(MAX_LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } req_t;

    // An access is an error when it is not word aligned or when its word
    // index (addr[31:2]) falls outside the array.
    function automatic logic addr_err(input logic [ADDR_W-1:0] addr,
                                      input int unsigned       depth);
        return (addr[1:0] != 2'b00) ||
               ({2'b00, addr[ADDR_W-1:2]} >= ADDR_W'(depth));
    endfunction

endpackage

// File: rtl/dmem_sram_array.sv
// dmem_sram_array
//   Word-organised storage with a synchronous byte-enabled write and a
//   registered read. Contents are never reset.
// Ports:
//   clk      - clock, all activity on the rising edge
//   i_we     - write strobe for the word at i_addr
//   i_re     - read strobe; o_rdata updates on the next edge
//   i_addr   - word index
//   i_wdata  - write data
//   i_be     - byte enables for the write, bit i enables byte i
//   o_rdata  - registered read data (holds until the next read strobe)
module dmem_sram_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [BE_W-1:0]   i_be,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // NOTE: the array and its read register carry no reset; a reset branch
    // would turn the block RAM into thousands of flops and would also break
    // the rule that stored data survives a reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
        // Read and write are never strobed together, so read-during-write
        // ordering on the same word does not arise.
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
//   Single-outstanding data-memory responder. A request is captured on the
//   valid/ready handshake, held for LATENCY wait-state cycles, then the store
//   is committed (or the load read) and the response presented until the
//   core takes it. Misaligned or out-of-range accesses respond with err=1,
//   rdata=0 and never touch the array.
// Ports:
//   clk         - clock
//   rst         - asynchronous active-low reset
//   req_valid   - request present          req_ready  - request accepted when high
//   req_we      - 1 store / 0 load         req_addr   - byte address
//   req_wdata   - store data               req_be     - store byte enables
//   resp_valid  - response present         resp_ready - core takes the response
//   resp_rdata  - load data (0 for stores and errors)
//   resp_err    - misaligned or out-of-range access
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2          // legal range 0..MAX_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    req_t              r_req;
    req_t              w_req_in;
    req_t              w_req_cur;
    logic              r_err;
    logic              r_ret_data;
    logic              w_accept;
    logic              w_fire;
    logic              w_err_cur;
    logic [DATA_W-1:0] w_sram_rdata;

    assign w_req_in = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
    assign w_accept = req_valid && req_ready;

    // With LATENCY=0 the memory access happens on the accept edge itself,
    // before the request register is loaded, so the live inputs are used.
    assign w_req_cur = (r_state == ST_IDLE) ? w_req_in : r_req;
    assign w_err_cur = addr_err(w_req_cur.addr, DEPTH);

    // The array is touched exactly once per request: on the edge that
    // enters RESP.
    assign w_fire = (w_state_nxt == ST_RESP) && (r_state != ST_RESP);

    // NOTE: every combinational output gets a default before the case, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (LATENCY == 0) begin
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_req      <= '0;
            r_err      <= 1'b0;
            r_ret_data <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_req <= w_req_in;
            end
            if (w_fire) begin
                r_err      <= w_err_cur;
                r_ret_data <= !w_err_cur && !w_req_cur.we;
            end
        end
    end

    dmem_sram_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sram (
        .clk     (clk),
        .i_we    (w_fire && w_req_cur.we && !w_err_cur),
        .i_re    (w_fire && !w_req_cur.we && !w_err_cur),
        .i_addr  (w_req_cur.addr[AW+1:2]),
        .i_wdata (w_req_cur.wdata),
        .i_be    (w_req_cur.be),
        .o_rdata (w_sram_rdata)
    );

    // Outputs are decoded from the state register, so they fall to their
    // idle values the instant reset is asserted.
    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);
    assign resp_err   = resp_valid && r_err;
    assign resp_rdata = (resp_valid && r_ret_data) ? w_sram_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int A_DEPTH = 1024;
    localparam int A_LAT   = 2;
    localparam int B_DEPTH = 16;
    localparam int B_LAT   = 0;
    localparam int REGION  = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_req_valid, a_req_ready, a_req_we, a_resp_valid, a_resp_ready, a_resp_err;
    logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
    logic [3:0]  a_req_be;
    logic        b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_ready, b_resp_err;
    logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
    logic [3:0]  b_req_be;

    int checks = 0;
    int errors = 0;

    logic [31:0] ma [A_DEPTH];
    logic [31:0] mb [B_DEPTH];

    dmem_responder #(.DEPTH(A_DEPTH), .LATENCY(A_LAT)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
    );

    dmem_responder #(.DEPTH(B_DEPTH), .LATENCY(B_LAT)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
    );

    // ---------------- reference model ----------------
    function automatic bit exp_err(input logic [31:0] addr, input int depth);
        return (addr % 4 != 0) || ((addr / 4) >= 32'(depth));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                          input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~mask) | (wdata & mask);
    endfunction

    task automatic a_expect(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, output logic [31:0] er, output logic ee);
        ee = exp_err(addr, A_DEPTH);
        er = '0;
        if (!ee) begin
            if (we) ma[addr / 4] = merge(ma[addr / 4], wdata, be);
            else    er = ma[addr / 4];
        end
    endtask

    // One complete transaction on instance A with resp_ready held high.
    // lat counts cycles from the accept cycle to the first resp_valid cycle.
    task automatic a_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output logic [31:0] rdata, output logic err,
                         output int lat);
        int n;
        rdata = '0; err = 1'b0; lat = 0;
        a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr;
        a_req_wdata = wdata; a_req_be = be; a_resp_ready = 1'b1;
        n = 0;
        while (a_req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        if (a_req_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL accept_timeout: req_ready=%b required 1", a_req_ready);
            a_req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        // Scramble the request bus so a missed capture shows up.
        a_req_valid = 1'b0; a_req_we = 1'($urandom); a_req_addr = $urandom;
        a_req_wdata = $urandom; a_req_be = 4'($urandom);
        lat = 1;
        while (a_resp_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        if (a_resp_valid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL resp_timeout: resp_valid=%b required 1", a_resp_valid);
            return;
        end
        rdata = a_resp_rdata;
        err   = a_resp_err;
        @(posedge clk); #1;
    endtask

    task automatic a_op(input string name, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
        logic [31:0] er, r;
        logic        ee, e;
        int          lat;
        a_expect(we, addr, wdata, be, er, ee);
        a_txn(we, addr, wdata, be, r, e, lat);
        checks++;
        if (r !== er) begin
            errors++;
            $display("FAIL %s rdata addr=%h: got %h expected %h", name, addr, r, er);
        end
        checks++;
        if (e !== ee) begin
            errors++;
            $display("FAIL %s err addr=%h: got %b expected %b", name, addr, e, ee);
        end
        checks++;
        if (lat != A_LAT + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, A_LAT + 1);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        a_req_valid = 0; a_req_we = 0; a_req_addr = 0; a_req_wdata = 0; a_req_be = 0; a_resp_ready = 0;
        b_req_valid = 0; b_req_we = 0; b_req_addr = 0; b_req_wdata = 0; b_req_be = 0; b_resp_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (a_req_ready !== 1'b1)  begin errors++; $display("FAIL reset_req_ready: got %b expected 1", a_req_ready); end
        checks++; if (a_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", a_resp_valid); end
        checks++; if (a_resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata: got %h expected 0", a_resp_rdata); end
        checks++; if (a_resp_err !== 1'b0)   begin errors++; $display("FAIL reset_resp_err: got %b expected 0", a_resp_err); end
        checks++; if (b_req_ready !== 1'b1)  begin errors++; $display("FAIL reset_b_req_ready: got %b expected 1", b_req_ready); end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_exit: resp_valid=%b req_ready=%b expected 0/1", a_resp_valid, a_req_ready);
        end
    endtask

    task automatic test_prefill();
        for (int w = 0; w < REGION; w++) a_op("prefill", 1'b1, 32'(4 * w), $urandom, 4'hF);
    endtask

    task automatic test_directed();
        a_op("st_full", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        a_op("ld_full", 1'b0, 32'h10, 32'h0, 4'h0);
        a_op("st_byte", 1'b1, 32'h10, 32'h000000AA, 4'h1);
        checks++; if (ma[4] !== 32'hDEADBEAA) begin errors++; $display("FAIL model_byte_merge: got %h expected deadbeaa", ma[4]); end
        a_op("ld_byte", 1'b0, 32'h10, 32'h0, 4'h0);
    endtask

    task automatic test_errors();
        a_op("ld_misaligned", 1'b0, 32'h12, 32'h0, 4'h0);
        a_op("ld_oob", 1'b0, 32'(4 * A_DEPTH), 32'h0, 4'h0);
        a_op("st_oob", 1'b1, 32'(4 * A_DEPTH), 32'hCAFEF00D, 4'hF);
        a_op("st_misaligned", 1'b1, 32'h0000_0009, 32'hCAFEF00D, 4'hF);
        a_op("st_be0", 1'b1, 32'h8, 32'h5555_5555, 4'h0);
        for (int w = 0; w < REGION; w++) a_op("ld_unchanged", 1'b0, 32'(4 * w), 32'h0, 4'h0);
        a_op("st_last", 1'b1, 32'(4 * (A_DEPTH - 1)), 32'h1234_5678, 4'hF);
        a_op("ld_last", 1'b0, 32'(4 * (A_DEPTH - 1)), 32'h0, 4'h0);
        a_op("ld_top", 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0);
    endtask

    task automatic test_random();
        logic [31:0] addr;
        int sel;
        for (int i = 0; i < 80; i++) begin
            sel = int'($urandom % 8);
            if (sel == 0)      addr = 32'(4 * ($urandom % REGION) + 1 + ($urandom % 3));
            else if (sel == 1) addr = 32'(4 * A_DEPTH) + 32'(4 * ($urandom % 4096));
            else               addr = 32'(4 * ($urandom % REGION));
            a_op("random", 1'($urandom), addr, $urandom, 4'($urandom));
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp;
        int n;
        exp = ma[5];
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'h14; a_req_be = 4'h0; a_resp_ready = 1'b0;
        checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL bp_idle: req_ready=%b expected 1", a_req_ready); end
        @(posedge clk); #1;
        // An intruding store that must not be accepted while busy.
        a_req_we = 1'b1; a_req_addr = 32'h18; a_req_wdata = ~ma[6]; a_req_be = 4'hF;
        n = 0;
        while (a_resp_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        for (int k = 0; k < 5; k++) begin
            checks++; if (a_resp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc%0d: got %b expected 1", k, a_resp_valid); end
            checks++; if (a_resp_rdata !== exp) begin errors++; $display("FAIL bp_rdata cyc%0d: got %h expected %h", k, a_resp_rdata, exp); end
            checks++; if (a_req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready cyc%0d: got %b expected 0", k, a_req_ready); end
            @(posedge clk); #1;
        end
        a_req_valid = 1'b0; a_resp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release: resp_valid=%b req_ready=%b expected 0/1", a_resp_valid, a_req_ready);
        end
        a_op("bp_no_store", 1'b0, 32'h18, 32'h0, 4'h0);
    endtask

    task automatic test_reset_in_wait();
        a_op("rw_old", 1'b1, 32'h20, 32'h1111_1111, 4'hF);
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h20; a_req_wdata = 32'h2222_2222;
        a_req_be = 4'hF; a_resp_ready = 1'b1;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        checks++; if (a_req_ready !== 1'b0) begin errors++; $display("FAIL rw_in_wait: req_ready=%b expected 0", a_req_ready); end
        rst = 1'b0;
        #1;
        checks++; if (a_req_ready !== 1'b1)   begin errors++; $display("FAIL rw_req_ready: got %b expected 1", a_req_ready); end
        checks++; if (a_resp_valid !== 1'b0)  begin errors++; $display("FAIL rw_resp_valid: got %b expected 0", a_resp_valid); end
        checks++; if (a_resp_rdata !== 32'h0 || a_resp_err !== 1'b0) begin
            errors++; $display("FAIL rw_resp_data: rdata=%h err=%b expected 0/0", a_resp_rdata, a_resp_err);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (a_resp_valid !== 1'b0) begin errors++; $display("FAIL rw_spurious: resp_valid=%b expected 0", a_resp_valid); end
        checks++; if (ma[8] !== 32'h1111_1111) begin errors++; $display("FAIL rw_model: got %h expected 11111111", ma[8]); end
        a_op("rw_after", 1'b0, 32'h20, 32'h0, 4'h0);
    endtask

    // Back-to-back traffic on the LATENCY=0 instance with req_valid held high.
    task automatic b_stream(input logic we, input int n);
        int acc_i, rsp_i, last_acc;
        int acc_cyc[$];
        logic [31:0] exp_q[$];
        logic [31:0] addr;
        acc_i = 0; rsp_i = 0; last_acc = 0;
        b_resp_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && rsp_i < n; cyc++) begin
            if (b_resp_valid === 1'b1) begin
                if (rsp_i >= acc_i) begin
                    checks++; errors++;
                    $display("FAIL lat0_spurious: response with no request outstanding");
                end else begin
                    checks++; if (b_resp_rdata !== exp_q[rsp_i]) begin errors++; $display("FAIL lat0_rdata #%0d: got %h expected %h", rsp_i, b_resp_rdata, exp_q[rsp_i]); end
                    checks++; if (b_resp_err !== 1'b0) begin errors++; $display("FAIL lat0_err #%0d: got %b expected 0", rsp_i, b_resp_err); end
                    checks++; if (cyc - acc_cyc[rsp_i] != B_LAT + 1) begin errors++; $display("FAIL lat0_latency #%0d: got %0d expected %0d", rsp_i, cyc - acc_cyc[rsp_i], B_LAT + 1); end
                end
                rsp_i++;
            end
            if (acc_i < n) begin
                addr = we ? 32'(4 * acc_i) : 32'(4 * ($urandom % 8));
                b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr;
                b_req_wdata = $urandom; b_req_be = 4'hF;
                if (b_req_ready === 1'b1) begin
                    if (acc_i > 0) begin
                        checks++; if (cyc - last_acc != 2) begin errors++; $display("FAIL lat0_interval: got %0d expected 2", cyc - last_acc); end
                    end
                    if (we) begin mb[addr / 4] = b_req_wdata; exp_q.push_back(32'h0); end
                    else    exp_q.push_back(mb[addr / 4]);
                    acc_cyc.push_back(cyc);
                    last_acc = cyc;
                    acc_i++;
                end
            end else begin
                b_req_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        b_req_valid = 1'b0;
        checks++; if (rsp_i != n) begin errors++; $display("FAIL lat0_count: got %0d responses expected %0d", rsp_i, n); end
    endtask

    task automatic test_latency0();
        b_stream(1'b1, 8);
        b_stream(1'b0, 8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_prefill();
        test_directed();
        test_errors();
        test_random();
        test_backpressure();
        test_reset_in_wait();
        test_latency0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
